// File: rtl/mesh_router_core.sv
// 5-port mesh router core: per-input FIFOs, XY routing, per-output round-robin
// arbitration and registered outputs. Optional activity counter: ROUTER_FLIT_COUNTER_EN.
module mesh_router_core #(
  parameter int DATA_W      = 32,
  parameter int X_W         = 2,
  parameter int Y_W         = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int WINDOW_LOG2 = 10,
  parameter int CNT_W       = 20
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [X_W+Y_W-1:0]                 id,
  input  logic [4:0]                         in_valid,
  input  logic [5*(DATA_W+Y_W+X_W)-1:0]      in_data,
  output logic [4:0]                         in_busy,
  output logic [4:0]                         out_valid,
  output logic [5*(DATA_W+Y_W+X_W)-1:0]      out_data,
  input  logic [4:0]                         out_busy,
  output logic [CNT_W-1:0]                   flit_count
);

  localparam int FLIT_W = DATA_W + Y_W + X_W;
  localparam int AW     = $clog2(FIFO_DEPTH);

  logic [FLIT_W-1:0] r_mem [5][FIFO_DEPTH];
  logic [AW-1:0]     r_wptr [5];
  logic [AW-1:0]     r_rptr [5];
  logic [AW:0]       r_cnt [5];
  logic [4:0]        r_busy;
  logic [4:0]        r_ovalid;
  logic [FLIT_W-1:0] r_odata [5];
  logic [2:0]        r_ptr [5];

  logic [4:0]        w_write;
  logic [4:0]        w_pop;
  logic [4:0]        w_grant;
  logic [4:0]        w_found;
  logic [2:0]        w_win [5];
  logic [4:0]        w_req [5];
  logic [FLIT_W-1:0] w_head [5];
  logic [AW:0]       w_cnt_nxt [5];

  assign w_write   = in_valid & ~r_busy;
  assign in_busy   = r_busy;
  assign out_valid = r_ovalid;

  // Head flit of each FIFO and its one-hot XY route request (X resolved first)
  always_comb begin
    for (int p = 0; p < 5; p++) begin
      w_head[p] = r_mem[p][r_rptr[p]];
      w_req[p]  = 5'b00000;
      if (r_cnt[p] == '0) begin
        w_req[p] = 5'b00000;
      end else if (w_head[p][X_W-1:0] > id[X_W-1:0]) begin
        w_req[p] = 5'b00010;
      end else if (w_head[p][X_W-1:0] < id[X_W-1:0]) begin
        w_req[p] = 5'b01000;
      end else if (w_head[p][X_W+:Y_W] > id[X_W+:Y_W]) begin
        w_req[p] = 5'b00001;
      end else if (w_head[p][X_W+:Y_W] < id[X_W+:Y_W]) begin
        w_req[p] = 5'b00100;
      end else begin
        w_req[p] = 5'b10000;
      end
      w_cnt_nxt[p] = r_cnt[p] + (AW+1)'(w_write[p]) - (AW+1)'(w_pop[p]);
    end
  end

  // Round-robin arbitration per output, searching from the port after the last winner
  always_comb begin : p_arb
    int idx;
    idx     = 0;
    w_grant = 5'b00000;
    w_pop   = 5'b00000;
    w_found = 5'b00000;
    for (int o = 0; o < 5; o++) begin
      w_win[o] = r_ptr[o];
      for (int i = 1; i <= 5; i++) begin
        idx = (int'(r_ptr[o]) + i) % 5;
        if (!w_found[o] && w_req[idx][o]) begin
          w_found[o] = 1'b1;
          w_win[o]   = 3'(idx);
        end else begin
          w_found[o] = w_found[o];
        end
      end
      w_grant[o] = w_found[o] & (~r_ovalid[o] | ~out_busy[o]);
    end
    for (int o = 0; o < 5; o++) begin
      for (int p = 0; p < 5; p++) begin
        if (w_grant[o] && (w_win[o] == 3'(p))) begin
          w_pop[p] = 1'b1;
        end else begin
          w_pop[p] = w_pop[p];
        end
      end
    end
  end

  // FIFO storage needs no reset: contents are only read when occupancy says valid
  always_ff @(posedge clk) begin
    for (int p = 0; p < 5; p++) begin
      if (w_write[p]) r_mem[p][r_wptr[p]] <= in_data[p*FLIT_W +: FLIT_W];
    end
  end

  // FIFO pointers, occupancy and registered full flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < 5; p++) begin
        r_wptr[p] <= '0;
        r_rptr[p] <= '0;
        r_cnt[p]  <= '0;
      end
      r_busy <= 5'b00000;
    end else begin
      for (int p = 0; p < 5; p++) begin
        if (w_write[p]) r_wptr[p] <= r_wptr[p] + 1'b1;
        if (w_pop[p])   r_rptr[p] <= r_rptr[p] + 1'b1;
        r_cnt[p]  <= w_cnt_nxt[p];
        r_busy[p] <= (w_cnt_nxt[p] == (AW+1)'(FIFO_DEPTH));
      end
    end
  end

  // Output registers and arbiter pointers; a grant reloads even while emptying
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int o = 0; o < 5; o++) begin
        r_odata[o] <= '0;
        r_ptr[o]   <= 3'd4;
      end
      r_ovalid <= 5'b00000;
    end else begin
      for (int o = 0; o < 5; o++) begin
        if (w_grant[o]) begin
          r_odata[o]  <= w_head[w_win[o]];
          r_ovalid[o] <= 1'b1;
          r_ptr[o]    <= w_win[o];
        end else if (r_ovalid[o] && !out_busy[o]) begin
          r_ovalid[o] <= 1'b0;
        end
      end
    end
  end

  // Pack output registers onto the flat output bus
  always_comb begin
    out_data = '0;
    for (int o = 0; o < 5; o++) begin
      out_data[o*FLIT_W +: FLIT_W] = r_odata[o];
    end
  end

`ifdef ROUTER_FLIT_COUNTER_EN
  logic [WINDOW_LOG2-1:0] r_win;
  logic [CNT_W-1:0]       r_acc;
  logic [CNT_W-1:0]       r_fc;
  logic [2:0]             w_pc;
  logic [CNT_W:0]         w_sum;
  logic [CNT_W-1:0]       w_sat;

  // Saturating accumulator including this cycle's writes
  always_comb begin
    w_pc = 3'd0;
    for (int p = 0; p < 5; p++) begin
      w_pc = w_pc + {2'b00, w_write[p]};
    end
    w_sum = {1'b0, r_acc} + (CNT_W+1)'(w_pc);
    if (w_sum[CNT_W]) begin
      w_sat = '1;
    end else begin
      w_sat = w_sum[CNT_W-1:0];
    end
  end

  // Window counter; latch and clear the accumulator on the last cycle of each window
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_win <= '0;
      r_acc <= '0;
      r_fc  <= '0;
    end else begin
      r_win <= r_win + 1'b1;
      if (&r_win) begin
        r_fc  <= w_sat;
        r_acc <= '0;
      end else begin
        r_acc <= w_sat;
      end
    end
  end

  assign flit_count = r_fc;
`else
  assign flit_count = '0;
`endif

endmodule

// File: tb/tb_mesh_router_core.sv
// Scoreboard bench for mesh_router_core: stimulus pushes expected flits per output,
// a negedge monitor pops and compares on every completed output transfer.
`timescale 1ns/1ps
module tb_mesh_router_core;
  localparam int DW = 32;
  localparam int XW = 2;
  localparam int YW = 2;
  localparam int FW = DW + YW + XW;
`ifdef ROUTER_FLIT_COUNTER_EN
  localparam logic [63:0] EXP_FC = 64'd16;
`else
  localparam logic [63:0] EXP_FC = 64'd0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [3:0]      id = 4'b0101;
  logic [4:0]      in_valid = 5'b00000;
  logic [5*FW-1:0] in_data = '0;
  logic [4:0]      out_busy = 5'b00000;
  wire  [4:0]      in_busy;
  wire  [4:0]      out_valid;
  wire  [5*FW-1:0] out_data;
  wire  [19:0]     flit_count;

  logic [FW-1:0] exp_q [5][$];
  int checks = 0;
  int failures = 0;

  mesh_router_core #(.DATA_W(DW), .X_W(XW), .Y_W(YW), .FIFO_DEPTH(4),
                     .WINDOW_LOG2(3), .CNT_W(20)) dut (
    .clk(clk), .reset(reset), .id(id), .in_valid(in_valid), .in_data(in_data),
    .in_busy(in_busy), .out_valid(out_valid), .out_data(out_data),
    .out_busy(out_busy), .flit_count(flit_count));

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] mk(input logic [1:0] y, input logic [1:0] x,
                                       input logic [31:0] pl);
    return {pl, y, x};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic put(input int p, input logic [FW-1:0] f, input int o);
    in_valid[p] = 1'b1;
    in_data[p*FW +: FW] = f;
    exp_q[o].push_back(f);
  endtask

  function automatic int pending();
    return exp_q[0].size() + exp_q[1].size() + exp_q[2].size() +
           exp_q[3].size() + exp_q[4].size();
  endfunction

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (pending() != 0 && n < 100) begin
      tick;
      n++;
    end
    chk(nm, 64'(pending()), 64'd0);
    repeat (3) tick;
  endtask

  // Monitor: every completed output transfer must match the next expected flit
  always @(negedge clk) begin
    if (reset) begin
      for (int o = 0; o < 5; o++) begin
        if (out_valid[o] && !out_busy[o]) begin
          checks++;
          if (exp_q[o].size() == 0) begin
            failures++;
            $display("FAIL out%0d_unexpected: got %h expected none", o, out_data[o*FW +: FW]);
          end else if (out_data[o*FW +: FW] !== exp_q[o][0]) begin
            failures++;
            $display("FAIL out%0d_data: got %h expected %h", o, out_data[o*FW +: FW], exp_q[o][0]);
            void'(exp_q[o].pop_front());
          end else begin
            void'(exp_q[o].pop_front());
          end
        end
      end
    end
  end

  initial begin
    // reset state
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_busy", 64'(in_busy), 64'd0);
    chk("rst_out_data", 64'(out_data[FW-1:0]) | 64'(out_data[4*FW +: FW]), 64'd0);
    chk("rst_flit_count", 64'(flit_count), 64'd0);
    tick;
    reset = 1'b1;
    tick;

    // local injection and zero-load latency
    put(4, mk(2'd1, 2'd3, 32'hA5), 1);
    tick;
    in_valid = 5'b00000;
    chk("lat_k_valid", 64'(out_valid), 64'd0);
    tick;
    chk("lat_k1_valid", 64'(out_valid), 64'h02);
    chk("lat_k1_data", 64'(out_data[FW +: FW]), 64'(mk(2'd1, 2'd3, 32'hA5)));
    tick;
    chk("lat_k2_drop", 64'(out_valid), 64'd0);
    drain("drain_local");

    // XY routing in every direction, X taking priority over Y
    put(4, mk(2'd1, 2'd0, 32'h11), 3); tick;
    put(4, mk(2'd2, 2'd1, 32'h12), 0); tick;
    put(4, mk(2'd0, 2'd1, 32'h13), 2); tick;
    put(4, mk(2'd1, 2'd1, 32'h14), 4); tick;
    put(4, mk(2'd0, 2'd2, 32'h15), 1); tick;
    put(4, mk(2'd3, 2'd0, 32'h16), 3); tick;
    in_valid = 5'b00000;
    drain("drain_route");

    // four contenders for E, two flits each: strict round-robin from N
    for (int r = 0; r < 2; r++) begin
      put(0, mk(2'd0, 2'd2, 32'h100 + 32'(r * 16)), 1);
      put(2, mk(2'd3, 2'd3, 32'h102 + 32'(r * 16)), 1);
      put(3, mk(2'd1, 2'd2, 32'h103 + 32'(r * 16)), 1);
      put(4, mk(2'd2, 2'd3, 32'h104 + 32'(r * 16)), 1);
      tick;
    end
    in_valid = 5'b00000;
    drain("drain_rr");

    // backpressure: fill W FIFO plus output register, 6th flit held
    out_busy[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_busy_low", 64'(in_busy[3]), 64'd0);
      put(3, mk(2'd1, 2'd3, 32'h200 + 32'(i)), 1);
      tick;
    end
    chk("bp_busy_after5", 64'(in_busy[3]), 64'd1);
    put(3, mk(2'd1, 2'd3, 32'h205), 1);
    for (int c = 0; c < 3; c++) begin
      chk("stall_valid", 64'(out_valid[1]), 64'd1);
      chk("stall_data", 64'(out_data[FW +: FW]), 64'(mk(2'd1, 2'd3, 32'h200)));
      chk("bp_held6", 64'(in_busy[3]), 64'd1);
      tick;
    end
    out_busy[1] = 1'b0;
    tick;
    chk("nobubble_valid", 64'(out_valid[1]), 64'd1);
    chk("nobubble_data", 64'(out_data[FW +: FW]), 64'(mk(2'd1, 2'd3, 32'h201)));
    begin
      int n;
      n = 0;
      while (in_busy[3] && n < 10) begin
        tick;
        n++;
      end
      chk("bp_unblock", 64'(in_busy[3]), 64'd0);
    end
    tick;
    in_valid = 5'b00000;
    drain("drain_bp");

    // reset mid-burst discards everything buffered
    out_busy[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      put(4, mk(2'd1, 2'd3, 32'h300 + 32'(i)), 1);
      put(0, mk(2'd1, 2'd0, 32'h310 + 32'(i)), 3);
      tick;
    end
    in_valid = 5'b00000;
    tick;
    #2;
    reset = 1'b0;
    for (int o = 0; o < 5; o++) exp_q[o].delete();
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_data", 64'(out_data[FW +: FW]), 64'd0);
    chk("midrst_busy", 64'(in_busy), 64'd0);
    out_busy = 5'b00000;
    tick;
    reset = 1'b1;
    repeat (10) tick;
    chk("post_rst_idle", 64'(out_valid), 64'd0);

    // activity window: 2 flits/cycle for one 8-cycle window, then an idle window
    reset = 1'b0;
    tick;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      put(4, mk(2'd1, 2'd3, 32'h400 + 32'(i)), 1);
      put(0, mk(2'd1, 2'd0, 32'h410 + 32'(i)), 3);
      tick;
    end
    in_valid = 5'b00000;
    chk("fc_window", 64'(flit_count), EXP_FC);
    repeat (8) tick;
    chk("fc_idle", 64'(flit_count), 64'd0);
    drain("drain_fc");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
